// File: rtl/axi4lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4lite_pkg
//  Description : Shared definitions for the AXI4-Lite timer peripheral:
//                register map, CTRL bit positions, response code and the
//                write/read channel state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi4lite_pkg;

  // Register map (2-bit word address)
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_LOAD   = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // CTRL register bit positions
  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ACK  = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ACK  = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axi4lite_timer_slave_timer_core.sv
`default_nettype none
// ============================================================================
//  Module      : timer_core
//  Description : Prescaled down-counter with auto-reload, sticky expiry flag
//                and the CTRL/LOAD/COUNT/STATUS storage. Bus writes arrive as
//                one-cycle strobes sharing a single data byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_core
  import axi4lite_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_wdata,
  input  logic       i_ctrl_we,
  input  logic       i_load_we,
  input  logic       i_count_we,
  input  logic       i_status_clr,
  output logic [2:0] o_ctrl,
  output logic [7:0] o_load,
  output logic [7:0] o_count,
  output logic       o_expired
);

  localparam logic [7:0] c_PRE_MAX = 8'(PRESCALE - 1);

  logic [7:0] r_pre;
  logic [2:0] r_ctrl;
  logic [7:0] r_load;
  logic [7:0] r_count;
  logic       r_expired;

  logic w_tick;
  logic w_zero_tick;

  assign w_tick      = r_ctrl[CTRL_EN] && (r_pre == c_PRE_MAX);
  assign w_zero_tick = w_tick && (r_count == 8'd0);

  // Prescaler: free-runs 0..PRESCALE-1 while enabled, parked at 0 otherwise
  always_ff @(posedge clk) begin
    if (rst || !r_ctrl[CTRL_EN]) begin
      r_pre <= 8'd0;
    end else if (r_pre == c_PRE_MAX) begin
      r_pre <= 8'd0;
    end else begin
      r_pre <= r_pre + 8'd1;
    end
  end

  // CTRL: bus write, then a one-shot expiry overrides only the enable bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= 3'd0;
    end else begin
      if (i_ctrl_we) begin
        r_ctrl <= i_wdata[2:0];
      end
      if (w_zero_tick && !r_ctrl[CTRL_AUTO_RELOAD]) begin
        r_ctrl[CTRL_EN] <= 1'b0;
      end
    end
  end

  // LOAD: plain bus-written reload value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load <= 8'd0;
    end else if (i_load_we) begin
      r_load <= i_wdata;
    end
  end

  // COUNT: a bus write takes precedence over decrement/reload on a tick
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (i_count_we) begin
      r_count <= i_wdata;
    end else if (w_tick) begin
      if (r_count != 8'd0) begin
        r_count <= r_count - 8'd1;
      end else if (r_ctrl[CTRL_AUTO_RELOAD]) begin
        r_count <= r_load;
      end
    end
  end

  // Expiry flag: sticky; a new expiry wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_expired <= 1'b0;
    end else if (w_zero_tick) begin
      r_expired <= 1'b1;
    end else if (i_status_clr) begin
      r_expired <= 1'b0;
    end
  end

  assign o_ctrl    = r_ctrl;
  assign o_load    = r_load;
  assign o_count   = r_count;
  assign o_expired = r_expired;

endmodule
`default_nettype wire

// File: rtl/axi4lite_timer_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi4lite_timer_slave
//  Description : AXI4-Lite slave (2-bit address, 8-bit data) fronting a
//                prescaled down-counter timer with interrupt output.
//                Independent write and read channel state machines.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_timer_slave
  import axi4lite_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] s_axi_awaddr,
  input  logic       s_axi_awvalid,
  output logic       s_axi_awready,
  input  logic [7:0] s_axi_wdata,
  input  logic       s_axi_wstrb,
  input  logic       s_axi_wvalid,
  output logic       s_axi_wready,
  output logic [1:0] s_axi_bresp,
  output logic       s_axi_bvalid,
  input  logic       s_axi_bready,
  input  logic [1:0] s_axi_araddr,
  input  logic       s_axi_arvalid,
  output logic       s_axi_arready,
  output logic [7:0] s_axi_rdata,
  output logic [1:0] s_axi_rresp,
  output logic       s_axi_rvalid,
  input  logic       s_axi_rready,
  output logic       irq
);

  wr_state_t  r_wr_state;
  rd_state_t  r_rd_state;
  logic [7:0] r_rdata;

  logic       w_wr_en;
  logic [2:0] w_ctrl;
  logic [7:0] w_load;
  logic [7:0] w_count;
  logic       w_expired;
  logic [7:0] w_rd_mux;

  // Register writes happen only in the single accept cycle
  assign w_wr_en = (r_wr_state == W_ACK) && s_axi_wstrb;

  timer_core #(
    .PRESCALE(PRESCALE)
  ) u_timer_core (
    .clk          (clk),
    .rst          (rst),
    .i_wdata      (s_axi_wdata),
    .i_ctrl_we    (w_wr_en && (s_axi_awaddr == ADDR_CTRL)),
    .i_load_we    (w_wr_en && (s_axi_awaddr == ADDR_LOAD)),
    .i_count_we   (w_wr_en && (s_axi_awaddr == ADDR_COUNT)),
    .i_status_clr (w_wr_en && (s_axi_awaddr == ADDR_STATUS) && s_axi_wdata[0]),
    .o_ctrl       (w_ctrl),
    .o_load       (w_load),
    .o_count      (w_count),
    .o_expired    (w_expired)
  );

  // Write channel: wait for address and data together, accept, respond
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
    end else begin
      case (r_wr_state)
        W_IDLE:  if (s_axi_awvalid && s_axi_wvalid) r_wr_state <= W_ACK;
        W_ACK:   r_wr_state <= W_RESP;
        W_RESP:  if (s_axi_bready) r_wr_state <= W_IDLE;
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // Read data selection; unused CTRL/STATUS bits read as zero
  always_comb begin
    w_rd_mux = 8'd0;
    case (s_axi_araddr)
      ADDR_CTRL:   w_rd_mux = {5'd0, w_ctrl};
      ADDR_LOAD:   w_rd_mux = w_load;
      ADDR_COUNT:  w_rd_mux = w_count;
      ADDR_STATUS: w_rd_mux = {7'd0, w_expired};
      default:     w_rd_mux = 8'd0;
    endcase
  end

  // Read channel: accept address, capture data once, hold until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_rdata    <= 8'd0;
    end else begin
      case (r_rd_state)
        R_IDLE:  if (s_axi_arvalid) r_rd_state <= R_ACK;
        R_ACK: begin
          r_rdata    <= w_rd_mux;
          r_rd_state <= R_DATA;
        end
        R_DATA:  if (s_axi_rready) r_rd_state <= R_IDLE;
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = (r_wr_state == W_ACK);
  assign s_axi_wready  = (r_wr_state == W_ACK);
  assign s_axi_bvalid  = (r_wr_state == W_RESP);
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_arready = (r_rd_state == R_ACK);
  assign s_axi_rvalid  = (r_rd_state == R_DATA);
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = RESP_OKAY;
  assign irq           = w_expired && w_ctrl[CTRL_IRQ_EN];

endmodule
`default_nettype wire
